// File: rtl/program_ram_loader_pkg.sv
// -----------------------------------------------------------------------------
// program_ram_loader_pkg
// Shared definitions for the program RAM loader: FSM state encoding, header
// byte positions within the load stream, and the length-decoding rule in
// which a length byte of zero stands for a full 256-byte image.
// -----------------------------------------------------------------------------
package program_ram_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_LOAD    = 3'd2,
        ST_CHK     = 3'd3,
        ST_RELEASE = 3'd4,
        ST_RUN     = 3'd5,
        ST_ERR     = 3'd6
    } ld_state_e;

    // Position of each header field in the stream (byte0 = base, byte1 = N).
    localparam logic [0:0] HDR_BASE_IDX = 1'b0;
    localparam logic [0:0] HDR_LEN_IDX  = 1'b1;

    // A length byte of zero encodes a full 256-byte load.
    localparam logic [8:0] LEN_ZERO_MEANS_256 = 9'd256;

    // Expand the raw length byte into a data-byte count.
    function automatic logic [8:0] decode_len(input logic [7:0] len_byte);
        return (len_byte == 8'd0) ? LEN_ZERO_MEANS_256 : {1'b0, len_byte};
    endfunction

    // State that follows acceptance of a given header field.
    function automatic ld_state_e hdr_next_state(input logic [0:0] hdr_idx);
        return (hdr_idx == HDR_LEN_IDX) ? ST_LOAD : ST_LEN;
    endfunction

endpackage

// File: rtl/program_ram_loader_ram_256x8.sv
// -----------------------------------------------------------------------------
// ram_256x8
// Synchronous RAM, one write port and one read port, registered read.
// A read of the address being written in the same cycle returns the old data.
// The storage array is never cleared; only the read register is reset.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset of the read register
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  registered read data (1-cycle latency)
// -----------------------------------------------------------------------------
module ram_256x8 #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_r [0:(2**AW)-1];

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port; old data on a same-address write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= 8'd0;
        end else begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/program_ram_loader.sv
// -----------------------------------------------------------------------------
// program_ram_loader
// 256x8 program/data RAM on the CPU data bus plus a byte-stream loader.
// Stream: base address, length N (0 = 256), then N data bytes. While loading
// the CPU is disabled; afterwards the CPU is enabled with reset held high for
// RST_HOLD rising edges of clk_in (sampled on clk_qzt), with the restart
// address set to base-1 so that execution begins at base. A new header byte
// in RUN starts another load.
//
// Optional build macro LOADER_CHECKSUM_EN: a checksum byte follows the data;
// base + N + data + checksum must be 0 mod 256, else the loader locks in an
// error state (ld_err=1, CPU disabled, loader stalled) until reset_n.
//
// Ports:
//   clk_qzt       in   system clock, all logic on rising edge
//   reset_n       in   asynchronous active-low reset
//   clk_in        in   CPU slave clock, sampled as data
//   cpu_addr      in   CPU memory address
//   cpu_wdata     in   CPU write data
//   cpu_we        in   CPU write enable
//   cpu_rdata     out  registered read data to CPU
//   ld_valid      in   loader byte valid
//   ld_data       in   loader byte
//   ld_ready      out  loader may transfer
//   cpu_en        out  CPU enable
//   cpu_reset     out  CPU reset request (active high)
//   cpu_res_addr  out  CPU restart address
//   busy          out  high from header accept until RUN
//   ld_err        out  checksum failure (LOADER_CHECKSUM_EN builds only)
// -----------------------------------------------------------------------------
module program_ram_loader
    import program_ram_loader_pkg::*;
#(
    parameter int AW       = 8,
    parameter int RST_HOLD = 2
) (
    input  logic          clk_qzt,
    input  logic          reset_n,
    input  logic          clk_in,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    input  logic          cpu_we,
    output logic [7:0]    cpu_rdata,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic          cpu_en,
    output logic          cpu_reset,
    output logic [AW-1:0] cpu_res_addr,
    output logic          busy
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic          ld_err
`endif
);

    localparam int HW = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD);

    ld_state_e     state_r, state_s;
    logic [AW-1:0] base_r, base_s;
    logic [AW-1:0] ptr_r, ptr_s;
    logic [8:0]    cnt_r, cnt_s;
    logic [HW-1:0] hold_r, hold_s;
    logic          clk_in_d_r;
    logic          cpu_en_r, cpu_en_s;
    logic          cpu_reset_r, cpu_reset_s;
    logic [AW-1:0] res_addr_r, res_addr_s;
    logic          busy_r, busy_s;
    logic          ld_ready_r, ld_ready_s;
    logic          accept_s;
    logic          clk_in_rise_s;
    logic          go_release_s;
    logic          ld_wr_s;
    logic          cpu_wr_s;
    logic          ram_we_s;
    logic [AW-1:0] ram_waddr_s;
    logic [7:0]    ram_wdata_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    sum_r, sum_s;
    logic [7:0]    chk_total_s;
    logic          ld_err_r, ld_err_s;
`endif

    assign accept_s      = ld_valid && ld_ready_r;
    assign clk_in_rise_s = clk_in && !clk_in_d_r;

    // Next-state and next-output logic of the loader FSM
    always_comb begin
        state_s      = state_r;
        base_s       = base_r;
        ptr_s        = ptr_r;
        cnt_s        = cnt_r;
        hold_s       = hold_r;
        cpu_en_s     = cpu_en_r;
        cpu_reset_s  = cpu_reset_r;
        res_addr_s   = res_addr_r;
        busy_s       = busy_r;
        go_release_s = 1'b0;
        ld_wr_s      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_s        = sum_r;
        chk_total_s  = sum_r + ld_data;
        ld_err_s     = ld_err_r;
`endif
        case (state_r)
            ST_IDLE, ST_RUN: begin
                if (accept_s) begin
                    base_s   = ld_data[AW-1:0];
                    cpu_en_s = 1'b0;
                    busy_s   = 1'b1;
                    state_s  = hdr_next_state(HDR_BASE_IDX);
`ifdef LOADER_CHECKSUM_EN
                    sum_s    = ld_data;
`endif
                end else begin
                    state_s = state_r;
                end
            end
            ST_LEN: begin
                if (accept_s) begin
                    cnt_s   = decode_len(ld_data);
                    ptr_s   = base_r;
                    state_s = hdr_next_state(HDR_LEN_IDX);
`ifdef LOADER_CHECKSUM_EN
                    sum_s   = sum_r + ld_data;
`endif
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    ld_wr_s = 1'b1;
                    ptr_s   = ptr_r + AW'(1);
                    cnt_s   = cnt_r - 9'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_s   = sum_r + ld_data;
                    if (cnt_r == 9'd1) begin
                        state_s = ST_CHK;
                    end else begin
                        state_s = ST_LOAD;
                    end
`else
                    if (cnt_r == 9'd1) begin
                        go_release_s = 1'b1;
                    end else begin
                        state_s = ST_LOAD;
                    end
`endif
                end else begin
                    state_s = state_r;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept_s) begin
                    if (chk_total_s == 8'd0) begin
                        go_release_s = 1'b1;
                    end else begin
                        state_s  = ST_ERR;
                        cpu_en_s = 1'b0;
                        ld_err_s = 1'b1;
                    end
                end else begin
                    state_s = state_r;
                end
            end
`endif
            ST_RELEASE: begin
                // Each clk_in rise seen on clk_qzt counts toward the hold time.
                if (clk_in_rise_s) begin
                    if (hold_r == HW'(RST_HOLD - 1)) begin
                        cpu_reset_s = 1'b0;
                        busy_s      = 1'b0;
                        hold_s      = '0;
                        state_s     = ST_RUN;
                    end else begin
                        hold_s = hold_r + HW'(1);
                    end
                end else begin
                    hold_s = hold_r;
                end
            end
            ST_ERR: begin
                state_s = ST_ERR;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Common entry into RELEASE: CPU restarts at base (PC = res_addr + 1).
        if (go_release_s) begin
            state_s     = ST_RELEASE;
            cpu_en_s    = 1'b1;
            cpu_reset_s = 1'b1;
            res_addr_s  = base_r - AW'(1);
            hold_s      = '0;
        end else begin
            res_addr_s = res_addr_s;
        end

        ld_ready_s = (state_s != ST_RELEASE) && (state_s != ST_ERR);
    end

    // FSM state, datapath and output registers
    always_ff @(posedge clk_qzt or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            base_r      <= '0;
            ptr_r       <= '0;
            cnt_r       <= 9'd0;
            hold_r      <= '0;
            clk_in_d_r  <= 1'b0;
            cpu_en_r    <= 1'b0;
            cpu_reset_r <= 1'b0;
            res_addr_r  <= '0;
            busy_r      <= 1'b0;
            ld_ready_r  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum_r       <= 8'd0;
            ld_err_r    <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            base_r      <= base_s;
            ptr_r       <= ptr_s;
            cnt_r       <= cnt_s;
            hold_r      <= hold_s;
            clk_in_d_r  <= clk_in;
            cpu_en_r    <= cpu_en_s;
            cpu_reset_r <= cpu_reset_s;
            res_addr_r  <= res_addr_s;
            busy_r      <= busy_s;
            ld_ready_r  <= ld_ready_s;
`ifdef LOADER_CHECKSUM_EN
            sum_r       <= sum_s;
            ld_err_r    <= ld_err_s;
`endif
        end
    end

    // Write-port mux: loader has priority; CPU writes only while running.
    assign cpu_wr_s    = cpu_we && cpu_en_r && !cpu_reset_r;
    assign ram_we_s    = ld_wr_s || cpu_wr_s;
    assign ram_waddr_s = ld_wr_s ? ptr_r : cpu_addr;
    assign ram_wdata_s = ld_wr_s ? ld_data : cpu_wdata;

    ram_256x8 #(
        .AW (AW)
    ) u_ram (
        .clk   (clk_qzt),
        .rst_n (reset_n),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .raddr (cpu_addr),
        .rdata (cpu_rdata)
    );

    assign ld_ready     = ld_ready_r;
    assign cpu_en       = cpu_en_r;
    assign cpu_reset    = cpu_reset_r;
    assign cpu_res_addr = res_addr_r;
    assign busy         = busy_r;
`ifdef LOADER_CHECKSUM_EN
    assign ld_err       = ld_err_r;
`endif

endmodule
